// File: rtl/bitty_exec_unit.sv
// Execute/control stage behind the Bitty fetch unit: latches an instruction on run,
// executes it against an 8x16 register file and ALU, and reports retirement with done.
module bitty_exec_unit #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] instr,
    output logic              done,
    output logic              en_memory_inst,
    output logic [DATA_W-1:0] memory_addr,
    output logic [DATA_W-1:0] last_alu_result,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_reg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_last;

    logic [2:0]        w_rx;
    logic [2:0]        w_ry;
    logic [7:0]        w_imm8;
    logic [2:0]        w_alu_sel;
    logic [1:0]        w_fmt;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;

    assign w_rx      = r_ir[15:13];
    assign w_ry      = r_ir[12:10];
    assign w_imm8    = r_ir[12:5];
    assign w_alu_sel = r_ir[4:2];
    assign w_fmt     = r_ir[1:0];

    assign w_a = r_regs[w_rx];
    assign w_b = (w_fmt == 2'b01) ? {{(DATA_W-8){1'b0}}, w_imm8} : r_regs[w_ry];

    always_comb begin
        w_alu = '0;
        case (w_alu_sel)
            3'b000: w_alu = w_a + w_b;
            3'b001: w_alu = w_a - w_b;
            3'b010: w_alu = w_a & w_b;
            3'b011: w_alu = w_a | w_b;
            3'b100: w_alu = w_a ^ w_b;
            3'b101: w_alu = w_a << w_b[3:0];
            3'b110: w_alu = w_a >> w_b[3:0];
            default: begin
                if (w_a == w_b)
                    w_alu = DATA_W'(0);
                else if (w_a > w_b)
                    w_alu = DATA_W'(1);
                else
                    w_alu = DATA_W'(2);
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (run) w_state_nxt = S_LATCH;
            S_LATCH: begin
                case (w_fmt)
                    2'b10:   w_state_nxt = S_DONE;
                    2'b11:   w_state_nxt = S_MEM;
                    default: w_state_nxt = S_EXEC;
                endcase
            end
            S_EXEC:  w_state_nxt = S_DONE;
            S_MEM:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_last  <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && run)
                r_ir <= instr;
            if (r_state == S_EXEC) begin
                r_regs[w_rx] <= w_alu;
                r_last       <= w_alu;
            end
            // Load data arrives on instr because fetch memory is asynchronous.
            if (r_state == S_MEM)
                r_regs[w_rx] <= instr;
        end
    end

    assign done            = (r_state == S_DONE) && !reset;
    assign en_memory_inst  = (r_state == S_MEM) && !reset;
    assign memory_addr     = en_memory_inst ? r_regs[w_ry] : '0;
    assign last_alu_result = r_last;
    assign dbg_reg         = r_regs[dbg_sel];

endmodule

// File: tb/tb_bitty_exec_unit.sv
// Directed bench for bitty_exec_unit: a per-instruction model tracks the register file
// and expected control outputs, and a negedge process compares the DUT against it.
module tb_bitty_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        done;
    logic        en_memory_inst;
    logic [15:0] memory_addr;
    logic [15:0] last_alu_result;
    logic [2:0]  dbg_sel = 3'd0;
    logic [15:0] dbg_reg;

    bitty_exec_unit #(.NUM_REGS(8), .DATA_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
        .instr           (instr),
        .done            (done),
        .en_memory_inst  (en_memory_inst),
        .memory_addr     (memory_addr),
        .last_alu_result (last_alu_result),
        .dbg_sel         (dbg_sel),
        .dbg_reg         (dbg_reg)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;
    logic [15:0] m_regs [8];
    logic [15:0] m_last = 16'h0;
    logic        exp_done = 1'b0;
    logic        exp_en = 1'b0;
    logic [15:0] exp_addr = 16'h0;
    logic        chk_en = 1'b0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("done", {15'b0, done}, {15'b0, exp_done});
        cmp("en_memory_inst", {15'b0, en_memory_inst}, {15'b0, exp_en});
        cmp("memory_addr", memory_addr, exp_addr);
        if (done === 1'b1) done_count++;
        if (chk_en) begin
            cmp("last_alu_result", last_alu_result, m_last);
            cmp($sformatf("dbg_reg[%0d]", dbg_sel), dbg_reg, m_regs[dbg_sel]);
        end
        dbg_sel = dbg_sel + 3'd1;
    end

    function automatic logic [15:0] enc_rr(input int rx, input int ry, input int sel);
        return {rx[2:0], ry[2:0], 5'b0, sel[2:0], 2'b00};
    endfunction

    function automatic logic [15:0] enc_ri(input int rx, input int imm, input int sel);
        return {rx[2:0], imm[7:0], sel[2:0], 2'b01};
    endfunction

    function automatic logic [15:0] model_alu(input int sel, input logic [15:0] a, input logic [15:0] b);
        int ua;
        int ub;
        ua = int'(a);
        ub = int'(b);
        case (sel)
            0: return 16'((ua + ub) % 65536);
            1: return 16'((ua - ub + 65536) % 65536);
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return 16'((ua * (1 << (ub % 16))) % 65536);
            6: return 16'(ua / (1 << (ub % 16)));
            default: return (ua == ub) ? 16'd0 : (ua > ub) ? 16'd1 : 16'd2;
        endcase
    endfunction

    task automatic do_reset();
        chk_en   = 1'b0;
        reset    = 1'b1;
        run      = 1'b0;
        exp_done = 1'b0;
        exp_en   = 1'b0;
        exp_addr = 16'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_last = 16'h0;
        chk_en = 1'b1;
    endtask

    // Issues one instruction starting in IDLE; returns #1 after the edge leaving DONE.
    task automatic do_instr(input logic [15:0] ins, input logic [15:0] mdata, input bit hold_run);
        int          rx;
        int          ry;
        int          fmt;
        logic [15:0] b;
        logic [15:0] res;
        rx  = int'(ins[15:13]);
        ry  = int'(ins[12:10]);
        fmt = int'(ins[1:0]);
        b   = (fmt == 1) ? {8'h00, ins[12:5]} : m_regs[ry];
        res = model_alu(int'(ins[4:2]), m_regs[rx], b);
        run   = 1'b1;
        instr = ins;
        @(posedge clk); #1;
        if (!hold_run) run = 1'b0;
        instr = 16'h5A5A;
        if (fmt == 2) begin
            @(posedge clk); #1;
            exp_done = 1'b1;
        end else begin
            @(posedge clk); #1;
            if (fmt == 3) begin
                instr    = mdata;
                exp_en   = 1'b1;
                exp_addr = m_regs[ry];
            end
            @(posedge clk); #1;
            instr    = 16'hA5A5;
            exp_en   = 1'b0;
            exp_addr = 16'h0;
            exp_done = 1'b1;
            if (fmt == 3) begin
                m_regs[rx] = mdata;
            end else begin
                m_regs[rx] = res;
                m_last     = res;
            end
        end
        @(posedge clk); #1;
        exp_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int done_before;
        do_reset();
        cmp("reset last_alu_result", last_alu_result, 16'h0000);

        do_instr(16'h6FE1, 16'h0, 0);
        cmp("6FE1 model R3", m_regs[3], 16'h007F);
        cmp("6FE1 last_alu_result", last_alu_result, 16'h007F);

        do_instr(enc_ri(1, 5, 0), 16'h0, 0);
        do_instr(enc_ri(2, 3, 0), 16'h0, 0);
        do_instr(16'h2800, 16'h0, 0);
        cmp("add R1", last_alu_result, 16'h0008);
        cmp("add model R1", m_regs[1], 16'h0008);
        do_instr(16'h281C, 16'h0, 0);
        cmp("cmp gt", last_alu_result, 16'h0001);
        do_instr(enc_rr(2, 2, 7), 16'h0, 0);
        cmp("cmp eq", last_alu_result, 16'h0000);

        do_instr(enc_rr(1, 1, 1), 16'h0, 0);
        do_instr(enc_ri(1, 8'hFF, 0), 16'h0, 0);
        do_instr(enc_ri(1, 8, 5), 16'h0, 0);
        cmp("shl", last_alu_result, 16'hFF00);
        do_instr(enc_ri(1, 8'hFF, 3), 16'h0, 0);
        cmp("or", last_alu_result, 16'hFFFF);
        do_instr(enc_ri(1, 1, 0), 16'h0, 0);
        cmp("wrap add", last_alu_result, 16'h0000);
        do_instr(enc_ri(1, 1, 1), 16'h0, 0);
        cmp("wrap sub", last_alu_result, 16'hFFFF);
        do_instr(enc_ri(7, 4, 6), 16'h0, 0);
        do_instr(enc_rr(1, 7, 6), 16'h0, 0);
        cmp("shr", last_alu_result, 16'hFFFF);
        do_instr(enc_ri(1, 8'h0F, 4), 16'h0, 0);
        cmp("xor", last_alu_result, 16'hFFF0);
        do_instr(enc_ri(1, 8'h3C, 2), 16'h0, 0);
        cmp("and", last_alu_result, 16'h0030);

        do_instr(enc_ri(5, 8'h10, 0), 16'h0, 0);
        do_instr(16'h9403, 16'hBEEF, 0);
        cmp("load model R4", m_regs[4], 16'hBEEF);
        cmp("load keeps last", last_alu_result, 16'h0010);

        done_before = done_count;
        do_instr(16'h0002, 16'h0, 1);
        do_instr(enc_ri(6, 8'h22, 0), 16'h0, 0);
        cmp("b2b done count", 16'(done_count - done_before), 16'd2);
        do_instr(enc_rr(5, 6, 7), 16'h0, 0);
        cmp("cmp lt", last_alu_result, 16'h0002);

        do_reset();
        run   = 1'b1;
        instr = 16'h6FE1;
        @(posedge clk); #1;
        run = 1'b0;
        @(posedge clk); #1;
        done_before = done_count;
        chk_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        cmp("reset abort no done", 16'(done_count - done_before), 16'd0);
        cmp("reset abort last", last_alu_result, 16'h0000);

        do_instr(16'h6FE1, 16'h0, 0);
        cmp("post-abort last", last_alu_result, 16'h007F);
        repeat (8) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitty_exec_unit.md
Name: bitty_exec_unit

Overview:
- Execute/control stage directly downstream of the instruction fetch unit.
- Consumes the fetched 16-bit `instr` whenever the branch logic asserts `run`.
- Decodes the instruction and runs it against an internal 8x16 register file and ALU.
- Returns `done`, `last_alu_result`, `en_memory_inst` and `memory_addr` to the fetch unit. Load data comes back on `instr` while `en_memory_inst` is high, because fetch memory is asynchronous.

Parameters:
- NUM_REGS, 8, register file depth (Rx/Ry fields are 3 bits).
- DATA_W, 16, datapath, instruction and address width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- run  input  1  start request from fetch `run_core`; sampled only in IDLE
- instr  input  16  instruction in IDLE/LATCH; memory read data in MEM
- done  output  1  one-cycle pulse when the instruction retires
- en_memory_inst  output  1  high only in MEM; steers fetch memory to `memory_addr`
- memory_addr  output  16  load address = R[Ry] in MEM, else 0
- last_alu_result  output  16  result of the most recent ALU instruction (registered)
- dbg_sel  input  3  debug register select
- dbg_reg  output  16  combinational R[dbg_sel]

Behaviour:
- Instruction fields:
  - Rx = [15:13], Ry = [12:10], imm8 = [12:5], alu_sel = [4:2], fmt = [1:0].
  - fmt 00: register ALU. fmt 01: immediate ALU, operand = zero-extended imm8. fmt 10: branch (handled by fetch; no-op here). fmt 11: load R[Rx] <= mem[R[Ry]].
- ALU, A = R[Rx], B = operand, 16-bit, wrap-around, no flags:
  - 000 A+B; 001 A-B; 010 A&B; 011 A|B; 100 A^B.
  - 101 A<<B[3:0]; 110 A>>B[3:0] (logical).
  - 111 compare: 0 if A==B, 1 if A>B unsigned, 2 if A<B.
- FSM states: IDLE, LATCH, EXEC, MEM, DONE.
  - IDLE: if run=1, next state is LATCH and ir <= instr.
  - LATCH: decode ir. fmt 00/01 -> EXEC; fmt 10 -> DONE; fmt 11 -> MEM.
  - EXEC: R[Rx] <= alu and last_alu_result <= alu at the clock edge; -> DONE.
  - MEM: en_memory_inst=1 and memory_addr=R[Ry] combinationally; R[Rx] <= instr at the clock edge; -> DONE. last_alu_result unchanged.
  - DONE: done=1 for exactly one cycle; -> IDLE.
- Latency from the edge that samples run to done high: ALU 3 cycles, load 3 cycles, branch 2 cycles. Registered writes are visible on dbg_reg the cycle after EXEC/MEM.
- Operands are read before write: Rx==Ry reads old values. R0 is an ordinary writable register.
- run is ignored outside IDLE. Deasserting run mid-instruction does not abort it.
- instr changes outside IDLE (other than in MEM) have no effect, because ir holds the instruction.
- Reset:
  - All registers, ir and last_alu_result go to 0; state goes to IDLE.
  - done, en_memory_inst and memory_addr are 0 during and after reset.
  - Reset mid-instruction discards the instruction with no register write and no done pulse. Reset wins over all other events.
- Back-to-back: IDLE may accept run on the cycle after DONE. There is no run acceptance in DONE itself.

Test Plan:
- Reset then run with instr=16'h6FE1 (R3 += 0x7F) -> done high exactly 3 cycles after the run-sampling edge; dbg_sel=3 gives 16'h007F; last_alu_result = 16'h007F.
- Load R1=5 and R2=3 via immediates, then 16'h2800 (R1 = R1+R2) -> R1 = 8. Then 16'h281C (compare R1,R2) -> last_alu_result = 1, R1 = 1. Compare with equal operands -> 0.
- Wrap: R1 = 16'hFFFF built via shifts/or/immediates, then add imm 1 -> R1 = 16'h0000. Sub 0-1 -> 16'hFFFF.
- Load 16'h9403 with R5 = 16'h0010 and the bench driving instr = 16'hBEEF while en_memory_inst=1 -> memory_addr = 16'h0010 for exactly one cycle; R4 = 16'hBEEF; last_alu_result unchanged.
- Branch fmt (16'h0002) -> done 2 cycles after run; no register or last_alu_result change. run held high continuously -> next instruction starts the cycle after DONE.
- Reset asserted in EXEC of 16'h6FE1 -> R3 stays 0, no done pulse, state IDLE. run deasserted in LATCH -> instruction still completes with done.
